// File: rtl/ascon_pkg.sv
// Shared Ascon types, round constants and permutation-core constants.
// Word 0 of ascon_state_t is x0; bit 63 of each word is the most significant.
package ascon_pkg;

    typedef logic [4:0][63:0] ascon_state_t;
    typedef logic [3:0]       rnd_t;

    // p12 round constants; entries 12..15 are unreachable padding for a full 4-bit index.
    localparam logic [7:0] AsconRcLut [16] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5, 8'h96, 8'h87,
        8'h78, 8'h69, 8'h5a, 8'h4b, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam int unsigned ASCON_P12_ROUNDS = 12;
    localparam int unsigned ASCON_P8_ROUNDS  = 8;

    // Linear-diffusion rotation pairs, one per state word.
    localparam int unsigned ASCON_ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int unsigned ASCON_ROT_B [5] = '{28, 39, 6, 17, 41};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } perm_state_e;

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_sp_layer.sv
// Combinational Ascon substitution (5-bit s-box on 64 bit-slices) followed by linear diffusion.
module ascon_sp_layer
    import ascon_pkg::*;
(
    input  ascon_state_t state_array_i,
    output ascon_state_t state_array_o
);

    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    ascon_state_t s;

    // Bitsliced s-box: all 64 columns evaluated in parallel with word-wide boolean ops.
    always_comb begin
        a0 = state_array_i[0] ^ state_array_i[4];
        a4 = state_array_i[4] ^ state_array_i[3];
        a2 = state_array_i[2] ^ state_array_i[1];
        a1 = state_array_i[1];
        a3 = state_array_i[3];

        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;

        a0 = a0 ^ t1;
        a1 = a1 ^ t2;
        a2 = a2 ^ t3;
        a3 = a3 ^ t4;
        a4 = a4 ^ t0;

        a1 = a1 ^ a0;
        a0 = a0 ^ a4;
        a3 = a3 ^ a2;
        a2 = ~a2;

        s[0] = a0;
        s[1] = a1;
        s[2] = a2;
        s[3] = a3;
        s[4] = a4;
    end

    always_comb begin
        state_array_o = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            state_array_o[i] = s[i] ^ rotr64(s[i], ASCON_ROT_A[i]) ^ rotr64(s[i], ASCON_ROT_B[i]);
        end
    end

endmodule

// File: rtl/constant_addition_layer.sv
// Ascon round-constant addition: XORs the round constant into the low byte of word 2.
// For p8 (round_config_i = 0) the round index is offset by 4 onto the tail of the p12 table.
module constant_addition_layer
    import ascon_pkg::*;
(
    input  ascon_state_t state_array_i,
    input  rnd_t         rnd_i,
    input  logic         round_config_i,
    output ascon_state_t state_array_o
);

    rnd_t idx;

    always_comb begin
        idx           = round_config_i ? rnd_i : rnd_t'(rnd_i + 4'd4);
        state_array_o = state_array_i;
        state_array_o[2][7:0] = state_array_i[2][7:0] ^ AsconRcLut[idx];
    end

endmodule

// File: rtl/ascon_permutation_seq.sv
// Iterative Ascon-p core: one round per clock, p12 or p8 selected per request,
// valid/ready handshake on both the request and the result side.
module ascon_permutation_seq
    import ascon_pkg::*;
#(
    parameter int unsigned ROUNDS_FULL    = ASCON_P12_ROUNDS,
    parameter int unsigned ROUNDS_REDUCED = ASCON_P8_ROUNDS
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic         round_config_i,
    input  ascon_state_t state_array_i,
    output logic         valid_o,
    input  logic         ready_i,
    output ascon_state_t state_array_o,
    output rnd_t         rnd_o,
    output logic         round_config_o,
    output logic         busy_o
);

    perm_state_e  fsm;
    ascon_state_t state_q;
    ascon_state_t cal_out;
    ascon_state_t sp_out;
    rnd_t         rnd_q;
    rnd_t         last_rnd;
    logic         cfg_q;
    logic         ready_q;
    logic         valid_q;
    logic         busy_q;

    assign last_rnd = cfg_q ? rnd_t'(ROUNDS_FULL - 1) : rnd_t'(ROUNDS_REDUCED - 1);

    constant_addition_layer u_cal (
        .state_array_i  (state_q),
        .rnd_i          (rnd_q),
        .round_config_i (cfg_q),
        .state_array_o  (cal_out)
    );

    ascon_sp_layer u_sp (
        .state_array_i (cal_out),
        .state_array_o (sp_out)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm     <= IDLE;
            state_q <= '0;
            rnd_q   <= '0;
            cfg_q   <= 1'b1;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (valid_i && ready_q) begin
                        state_q <= state_array_i;
                        cfg_q   <= round_config_i;
                        rnd_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        fsm     <= RUN;
                    end
                end
                RUN: begin
                    state_q <= sp_out;
                    if (rnd_q == last_rnd) begin
                        rnd_q   <= '0;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        fsm     <= DONE;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        fsm     <= IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    rnd_q   <= '0;
                    fsm     <= IDLE;
                end
            endcase
        end
    end

    assign ready_o        = ready_q;
    assign valid_o        = valid_q;
    assign busy_o         = busy_q;
    assign rnd_o          = rnd_q;
    assign round_config_o = cfg_q;
    assign state_array_o  = state_q;

endmodule
